// File: rtl/rgb_breath_sequencer_if.sv
// ---------------------------------------------------------------------------
// rgb_breath_sequencer_if
//   Bundles the pattern-select input and the LED-side outputs of the
//   breathing sequencer.
//   master : drives sw, observes the duty words / status (board / bench side)
//   slave  : the sequencer itself
//   sw          2  pattern select (asynchronous to clk)
//   R/G/B_time_out 8 duty words toward RGB_LED_0
//   cycle_done  1  one-clk pulse at the end of each pattern period
//   state_out   3  FSM state for debug
// ---------------------------------------------------------------------------
interface rgb_breath_sequencer_if;
    logic [1:0] sw;
    logic [7:0] R_time_out;
    logic [7:0] G_time_out;
    logic [7:0] B_time_out;
    logic       cycle_done;
    logic [2:0] state_out;

    modport master (
        output sw,
        input  R_time_out, G_time_out, B_time_out, cycle_done, state_out
    );

    modport slave (
        input  sw,
        output R_time_out, G_time_out, B_time_out, cycle_done, state_out
    );
endinterface

// File: rtl/rgb_breath_sequencer.sv
// ---------------------------------------------------------------------------
// rgb_breath_sequencer
//   Breathing pattern source for one RGB PWM channel set. A prescaler
//   produces a level-step tick; an FSM ramps a level up, holds, ramps down,
//   holds. sw selects off / white / R->G->B cycle / R->G->B crossfade.
// Ports
//   clk  system clock (shared with RGB_LED_0)
//   rst  asynchronous active-high reset
//   bus  slave side of rgb_breath_sequencer_if (sw in, duty words/status out)
// ---------------------------------------------------------------------------
module rgb_breath_sequencer #(
    parameter int STEP_DIV   = 195312,
    parameter int MAX_LEVEL  = 255,
    parameter int HOLD_STEPS = 64
) (
    input logic                   clk,
    input logic                   rst,
    rgb_breath_sequencer_if.slave bus
);
    localparam int PW = $clog2(STEP_DIV);
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_STEPS - 1);
    localparam logic [7:0]    MAX_L      = 8'(MAX_LEVEL);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HI   = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LO   = 3'd4
    } state_t;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    state_t        state_q, state_d;
    logic [7:0]    level_q, level_d;
    logic [1:0]    chan_q, chan_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    sync1_q, sync2_q;
    logic          done_q, done_d;
    logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;

    logic       tick;
    logic       restart;
    logic [1:0] mode;
    logic [1:0] chan_nxt;
    logic [7:0] fade;

    assign mode = sync2_q;
    assign tick = (presc_q == PRESC_LAST);
    // Restart is taken on the edge where the new mode lands in sync2, so the
    // pattern state and the mode switch together and outputs follow one clk later.
    assign restart  = (sync1_q != sync2_q);
    assign chan_nxt = (chan_q == CH_B) ? CH_R : chan_q + 2'd1;
    assign fade     = MAX_L - level_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            level_q <= '0;
            chan_q  <= CH_R;
            hold_q  <= '0;
            presc_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            done_q  <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            chan_q  <= chan_d;
            hold_q  <= hold_d;
            presc_q <= presc_d;
            sync1_q <= bus.sw;
            sync2_q <= sync1_q;
            done_q  <= done_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        chan_d  = chan_q;
        hold_d  = hold_q;
        presc_d = tick ? '0 : presc_q + PW'(1);
        done_d  = 1'b0;
        if (restart) begin
            presc_d = '0;
            level_d = '0;
            hold_d  = '0;
            chan_d  = CH_R;
            state_d = (sync1_q == 2'b00) ? IDLE : RAMP_UP;
        end else if (tick) begin
            case (state_q)
                RAMP_UP: begin
                    if (level_q < MAX_L) level_d = level_q + 8'd1;
                    if (level_q >= MAX_L - 8'd1) begin
                        state_d = HOLD_HI;
                        hold_d  = '0;
                    end
                end
                HOLD_HI: begin
                    if (hold_q == HOLD_LAST) begin
                        if (mode == 2'b11) begin
                            // Crossfade never ramps down: the next colour's
                            // ramp up is the previous colour's fade out.
                            chan_d  = chan_nxt;
                            level_d = '0;
                            done_d  = 1'b1;
                            state_d = RAMP_UP;
                        end else begin
                            state_d = RAMP_DOWN;
                        end
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                RAMP_DOWN: begin
                    if (level_q != 8'd0) level_d = level_q - 8'd1;
                    if (level_q <= 8'd1) begin
                        state_d = HOLD_LO;
                        hold_d  = '0;
                    end
                end
                HOLD_LO: begin
                    if (hold_q == HOLD_LAST) begin
                        if (mode == 2'b10) chan_d = chan_nxt;
                        done_d  = 1'b1;
                        state_d = RAMP_UP;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output mapping (registered next clk)
    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (mode == 2'b01) begin
            r_d = level_q;
            g_d = level_q;
            b_d = level_q;
        end else if (mode[1]) begin
            // Mode 11 also drives the previous channel with the complement.
            case (chan_q)
                CH_R: begin
                    r_d = level_q;
                    if (mode[0]) b_d = fade;
                end
                CH_G: begin
                    g_d = level_q;
                    if (mode[0]) r_d = fade;
                end
                default: begin
                    b_d = level_q;
                    if (mode[0]) g_d = fade;
                end
            endcase
        end
    end

    assign bus.R_time_out = r_q;
    assign bus.G_time_out = g_q;
    assign bus.B_time_out = b_q;
    assign bus.cycle_done = done_q;
    assign bus.state_out  = state_q;
endmodule

// File: tb/tb_rgb_breath_sequencer.sv
// Directed bench: STEP_DIV=4, MAX_LEVEL=4, HOLD_STEPS=2. t counts negedges
// after reset release; a mode change driven at t=S restarts the pattern on
// posedge S+2 (=R), level k is visible on the outputs from t=R+1+4k, and a
// full period (cycle_done) is 48 clks after R.
module tb_rgb_breath_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   t = 0;
    int   done_cnt = 0;
    int   snap = 0;

    rgb_breath_sequencer_if bus();

    rgb_breath_sequencer #(
        .STEP_DIV  (4),
        .MAX_LEVEL (4),
        .HOLD_STEPS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rgb(input string tag, input int r, input int g, input int b);
        chk({tag, ".R"}, int'(bus.R_time_out), r);
        chk({tag, ".G"}, int'(bus.G_time_out), g);
        chk({tag, ".B"}, int'(bus.B_time_out), b);
    endtask

    // Advance to negedge number k, counting cycle_done pulses on the way.
    task automatic to(input int k);
        while (t < k) begin
            @(negedge clk);
            t++;
            if (bus.cycle_done === 1'b1) done_cnt++;
        end
    endtask

    initial begin
        bus.sw = 2'b01;
        repeat (3) @(negedge clk);
        chk_rgb("rst", 0, 0, 0);
        chk("rst.state", int'(bus.state_out), 0);
        chk("rst.done", int'(bus.cycle_done), 0);
        rst = 1'b0;

        // Power-up into white breathing, restart at R=2
        to(1);  chk("w.t1.state", int'(bus.state_out), 0);
        to(2);  chk("w.t2.state", int'(bus.state_out), 1);
        to(6);  chk_rgb("w.t6", 0, 0, 0);
        to(7);  chk_rgb("w.lvl1", 1, 1, 1);
        to(11); chk_rgb("w.lvl2", 2, 2, 2);
        to(15); chk_rgb("w.lvl3", 3, 3, 3);
        to(19); chk_rgb("w.lvl4", 4, 4, 4);
        chk("w.hold_hi", int'(bus.state_out), 2);
        to(27); chk("w.ramp_dn", int'(bus.state_out), 3);
        chk_rgb("w.t27", 4, 4, 4);
        to(31); chk_rgb("w.dn3", 3, 3, 3);
        to(43); chk_rgb("w.dn0", 0, 0, 0);
        chk("w.hold_lo", int'(bus.state_out), 4);
        to(49); chk("w.t49.done", int'(bus.cycle_done), 0);
        to(50); chk("w.t50.done", int'(bus.cycle_done), 1);
        chk("w.t50.state", int'(bus.state_out), 1);
        to(51); chk("w.t51.done", int'(bus.cycle_done), 0);
        chk("w.pulses", done_cnt, 1);

        // Colour cycle, restart at R=62
        to(60); bus.sw = 2'b10;
        to(62); snap = done_cnt;
        to(63);  chk_rgb("cc.start", 0, 0, 0);
        to(67);  chk_rgb("cc.r1", 1, 0, 0);
        to(79);  chk_rgb("cc.r4", 4, 0, 0);
        to(103); chk_rgb("cc.r0", 0, 0, 0);
        to(110); chk("cc.done1", int'(bus.cycle_done), 1);
        to(115); chk_rgb("cc.g1", 0, 1, 0);
        to(127); chk_rgb("cc.g4", 0, 4, 0);
        to(158); chk("cc.done2", int'(bus.cycle_done), 1);
        to(163); chk_rgb("cc.b1", 0, 0, 1);
        to(175); chk_rgb("cc.b4", 0, 0, 4);
        to(206); chk("cc.done3", int'(bus.cycle_done), 1);
        to(211); chk_rgb("cc.r1again", 1, 0, 0);
        chk("cc.pulses", done_cnt - snap, 3);

        // Crossfade, restart at R=214
        to(212); bus.sw = 2'b11;
        to(214); snap = done_cnt;
        for (int k = 215; k <= 274; k++) begin
            to(k);
            chk("xf.sum", int'(bus.R_time_out) + int'(bus.G_time_out) + int'(bus.B_time_out), 4);
            if (k == 215) chk_rgb("xf.start", 0, 0, 4);
            if (k == 219) chk_rgb("xf.r1", 1, 0, 3);
            if (k == 231) chk_rgb("xf.r4", 4, 0, 0);
            if (k == 238) chk("xf.done", int'(bus.cycle_done), 1);
            if (k == 239) chk_rgb("xf.g0", 4, 0, 0);
            if (k == 243) chk_rgb("xf.g1", 3, 1, 0);
            if (k == 255) chk_rgb("xf.g4", 0, 4, 0);
        end
        chk("xf.pulses", done_cnt - snap, 2);

        // Mode change mid-ramp: 01 at 276 (R=278), 10 at level 2 (R=289)
        to(276); bus.sw = 2'b01;
        to(287); chk_rgb("mc.lvl2", 2, 2, 2);
        bus.sw = 2'b10;
        snap = done_cnt;
        to(289); chk_rgb("mc.pre", 2, 2, 2);
        to(290); chk_rgb("mc.restart", 0, 0, 0);
        chk("mc.state", int'(bus.state_out), 1);
        to(294); chk_rgb("mc.r1", 1, 0, 0);
        to(300); chk("mc.no_done", done_cnt - snap, 0);

        // Off during HOLD_HI: sw=00 at 307, restart at 309
        to(307); chk("off.hold_hi", int'(bus.state_out), 2);
        chk_rgb("off.pre", 4, 0, 0);
        bus.sw = 2'b00;
        to(309); chk("off.idle", int'(bus.state_out), 0);
        for (int k = 310; k <= 409; k++) begin
            to(k);
            chk("off.quiet", int'({bus.R_time_out, bus.G_time_out, bus.B_time_out,
                                   bus.cycle_done, bus.state_out}), 0);
        end

        // Asynchronous reset mid-pattern
        to(420); bus.sw = 2'b01;
        to(440); chk_rgb("ar.pre", 4, 4, 4);
        to(441);
        rst = 1'b1;
        #1;
        chk_rgb("ar.clear", 0, 0, 0);
        chk("ar.state", int'(bus.state_out), 0);
        chk("ar.done", int'(bus.cycle_done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
